// File: rtl/spi_rx_slave.sv
// Serial word receiver for the SCLK/CS/DO link: samples DATA_W bits LSB first on
// SCLK rising edges while CS is low and hands the word out with valid/ready.
module spi_rx_slave #(
  parameter int DATA_W      = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_in,
  input  logic              cs_n_in,
  input  logic              di_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  logic sclk_s;
  logic cs_n_s;
  logic di_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sclk_s = sclk_in;
      assign cs_n_s = cs_n_in;
      assign di_s   = di_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
      logic [SYNC_STAGES-1:0] cs_n_sync_q, cs_n_sync_d;
      logic [SYNC_STAGES-1:0] di_sync_q,   di_sync_d;

      // Shift each input one stage further down its synchronizer chain.
      always_comb begin
        sclk_sync_d    = sclk_sync_q;
        cs_n_sync_d    = cs_n_sync_q;
        di_sync_d      = di_sync_q;
        sclk_sync_d[0] = sclk_in;
        cs_n_sync_d[0] = cs_n_in;
        di_sync_d[0]   = di_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sclk_sync_d[i] = sclk_sync_q[i-1];
          cs_n_sync_d[i] = cs_n_sync_q[i-1];
          di_sync_d[i]   = di_sync_q[i-1];
        end
      end

      // Synchronizer flops; CS resets to its inactive (high) level.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sclk_sync_q <= '0;
          cs_n_sync_q <= '1;
          di_sync_q   <= '0;
        end else begin
          sclk_sync_q <= sclk_sync_d;
          cs_n_sync_q <= cs_n_sync_d;
          di_sync_q   <= di_sync_d;
        end
      end

      assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
      assign cs_n_s = cs_n_sync_q[SYNC_STAGES-1];
      assign di_s   = di_sync_q[SYNC_STAGES-1];
    end
  endgenerate

  state_t             state_q,     state_d;
  logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
  logic [DATA_W-1:0]  shreg_q,     shreg_d;
  logic [DATA_W-1:0]  rx_data_q,   rx_data_d;
  logic               rx_valid_q,  rx_valid_d;
  logic               overrun_q,   overrun_d;
  logic               frame_err_q, frame_err_d;
  logic               busy_q,      busy_d;
  logic               sclk_dly_q;
  logic               rise_s;

  assign rise_s = sclk_s & ~sclk_dly_q;

  // Next-state, shift register and output-register logic.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (!cs_n_s) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        // CS release wins over a coincident rise; a partial word is dropped.
        if (cs_n_s) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          if (bit_cnt_q != '0) begin
            frame_err_d = 1'b1;
            shreg_d     = '0;
          end else begin
            frame_err_d = 1'b0;
          end
        end else if (rise_s) begin
          for (int i = 0; i < DATA_W; i++) begin
            if (bit_cnt_q == CNT_W'(i)) begin
              shreg_d[i] = di_s;
            end else begin
              shreg_d[i] = shreg_q[i];
            end
          end
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end

      DONE: begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
        overrun_d  = rx_valid_q & ~rx_ready;
        bit_cnt_d  = '0;
        if (!cs_n_s) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      sclk_dly_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      sclk_dly_q  <= sclk_s;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
